// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I constants for the front end
package rv32i_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0001_0000;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO with flush; full/empty decided by count
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end
  always_ff @(posedge clk)
    if (!rst && !flush && push_ok) mem[wr_ptr] <= din;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage owning the fetch PC, feeding ID from a prefetch queue
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter int          XLEN     = rv32i_pkg::XLEN,
  parameter int          DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
  parameter int          PC_STEP  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [XLEN-1:0]            iad,
  output logic                       ireq,
  input  logic [31:0]                idt,
  input  logic                       acki_n,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [XLEN-1:0]            id_pc,
  output logic [31:0]                id_ir,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  logic [XLEN-1:0]    fetch_pc;
  logic [XLEN+31:0]   head;
  logic               full, empty, accept;
  assign iad      = fetch_pc;
  assign ireq     = !rst && !redirect && !full;
  assign accept   = ireq && !acki_n;
  assign id_valid = !empty;
  assign id_pc    = empty ? '0 : head[XLEN+31:32];
  assign id_ir    = empty ? NOP_INSN : head[31:0];
  always_ff @(posedge clk) begin
    if (rst) fetch_pc <= RESET_PC;
    else if (redirect) fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
    else if (accept) fetch_pc <= fetch_pc + XLEN'(PC_STEP);
  end
  fetch_queue #(.WIDTH(XLEN+32), .DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (id_valid && id_ready && !redirect),
    .flush (redirect),
    .din   ({fetch_pc, idt}),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch, stall, backpressure, redirect, wrap and reset priority
module tb_fetch_unit;
  logic        clk = 0;
  logic        rst, ireq, acki_n, redirect, id_valid, id_ready;
  logic [31:0] iad, idt, redirect_pc, id_pc, id_ir;
  logic [2:0]  count;
  int n_cmp = 0, n_err = 0;
  localparam logic [31:0] NOP = 32'h0000_0013;
  always #5 clk = ~clk;
  assign idt = iad ^ 32'hDEAD_BEEF;
  fetch_unit dut (
    .clk(clk), .rst(rst), .iad(iad), .ireq(ireq), .idt(idt), .acki_n(acki_n),
    .redirect(redirect), .redirect_pc(redirect_pc), .id_valid(id_valid),
    .id_ready(id_ready), .id_pc(id_pc), .id_ir(id_ir), .count(count)
  );
  function automatic logic [31:0] ins(input logic [31:0] pc);
    return pc ^ 32'hDEAD_BEEF;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic head(input string tag, input logic [31:0] pc, input logic [2:0] cnt);
    chk({tag, "_valid"}, 32'(id_valid), 32'd1);
    chk({tag, "_pc"}, id_pc, pc);
    chk({tag, "_ir"}, id_ir, ins(pc));
    chk({tag, "_count"}, 32'(count), 32'(cnt));
  endtask
  task automatic empty_chk(input string tag);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_valid"}, 32'(id_valid), 0);
    chk({tag, "_pc"}, id_pc, 0);
    chk({tag, "_ir"}, id_ir, NOP);
  endtask
  initial begin
    rst = 1; acki_n = 1; id_ready = 0; redirect = 0; redirect_pc = 0;
    tick(); tick();
    empty_chk("reset");
    chk("reset_ireq", 32'(ireq), 0);
    rst = 0; acki_n = 0; id_ready = 1;
    #1;
    chk("first_iad", iad, 32'h0001_0000);
    chk("first_ireq", 32'(ireq), 1);
    tick(); head("s0", 32'h0001_0000, 1);
    chk("s0_iad", iad, 32'h0001_0004);
    tick(); head("s1", 32'h0001_0004, 1);
    tick(); head("s2", 32'h0001_0008, 1);
    acki_n = 1;
    tick(); empty_chk("stall1");
    chk("stall1_iad", iad, 32'h0001_000C);
    chk("stall1_ireq", 32'(ireq), 1);
    tick(); tick();
    empty_chk("stall3");
    chk("stall3_iad", iad, 32'h0001_000C);
    acki_n = 0;
    tick(); head("resume", 32'h0001_000C, 1);
    chk("resume_iad", iad, 32'h0001_0010);
    rst = 1;
    tick(); empty_chk("rst2");
    rst = 0; id_ready = 0;
    tick(); tick(); tick(); tick();
    head("bp_full", 32'h0001_0000, 4);
    chk("bp_ireq", 32'(ireq), 0);
    chk("bp_iad", iad, 32'h0001_0010);
    tick();
    chk("bp_hold_count", 32'(count), 4);
    chk("bp_hold_iad", iad, 32'h0001_0010);
    id_ready = 1;
    tick(); head("pop1", 32'h0001_0004, 3);
    chk("pop1_iad", iad, 32'h0001_0010);
    chk("pop1_ireq", 32'(ireq), 1);
    tick(); head("pop2", 32'h0001_0008, 3);
    chk("pop2_iad", iad, 32'h0001_0014);
    tick(); head("pop3", 32'h0001_000C, 3);
    id_ready = 0;
    tick(); chk("refill_count", 32'(count), 4);
    redirect = 1; redirect_pc = 32'h0002_0046;
    #1 chk("redir_ireq", 32'(ireq), 0);
    tick();
    redirect = 0;
    empty_chk("redir");
    chk("redir_iad", iad, 32'h0002_0044);
    tick(); head("redir_t0", 32'h0002_0044, 1);
    id_ready = 1;
    tick(); head("redir_t1", 32'h0002_0048, 1);
    redirect = 1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 0;
    empty_chk("wrap_redir");
    chk("wrap_iad", iad, 32'hFFFF_FFFC);
    tick(); head("wrap0", 32'hFFFF_FFFC, 1);
    chk("wrap0_iad", iad, 32'h0000_0000);
    tick(); head("wrap1", 32'h0000_0000, 1);
    id_ready = 0;
    tick(); chk("pri_pre_count", 32'(count), 2);
    rst = 1; redirect = 1; redirect_pc = 32'h0003_0000;
    tick();
    rst = 0; redirect = 0;
    empty_chk("pri");
    chk("pri_iad", iad, 32'h0001_0000);
    tick(); head("pri_fetch", 32'h0001_0000, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
